mux2to1_triple: RTL and testbench
=================================

Name: mux2to1_triple

Overview:
- Single-bit-per-lane 2:1 selector built as three independent implementations of the same function: conditional-operator, if/else and case.
- The three paths must always agree. A registered stage captures the selected value and cross-checks the three paths.
- Used as a reference/self-checking selector primitive in datapath muxing.
- Selection is purely combinational. Registers serve only observation and checking.

Parameters:
- WIDTH, 1, bit width of in0/in1 and of every data output.
- CNT_W, 8, width of the mismatch event counter.

Ports:
- clk  input  1  rising-edge clock for registered outputs.
- rst_n  input  1  asynchronous active-low reset.
- in0  input  WIDTH  data selected when sel=0.
- in1  input  WIDTH  data selected when sel=1.
- sel  input  1  select.
- out_cond  output  WIDTH  combinational, conditional-operator implementation.
- out_if  output  WIDTH  combinational, if/else implementation (always block, full assignment, no latch).
- out_case  output  WIDTH  combinational, case-on-sel implementation, with default branch driving in0.
- out_q  output  WIDTH  registered copy of out_cond.
- mismatch  output  1  sticky flag, set when any two combinational paths ever differ at a clock edge.
- mismatch_cnt  output  CNT_W  number of clock edges at which a mismatch was sampled.

Behaviour:
- Combinational rule, all three paths: out = sel ? in1 : in0, bitwise over WIDTH.
- Zero latency. Outputs settle in the same delta cycle as an input change.
- Combinational outputs do not depend on clk or rst_n.
- sel is treated as known (0/1) for functional purposes. The if and case paths select in0 for any sel value other than 1.
- Truth table, WIDTH=1, listed as {sel,in1,in0} -> out:
  - 000->0, 001->1, 010->0, 011->1
  - 100->0, 101->0, 110->1, 111->1
- Async reset (rst_n=0), taking effect immediately and independent of clk:
  - out_q=0, mismatch=0, mismatch_cnt=0.
- Each rising clk edge with rst_n=1:
  - out_q <= out_cond (one-cycle latency).
  - err = (out_cond!=out_if) | (out_cond!=out_case), evaluated only when sel is 0 or 1.
  - If err: mismatch <= 1, and mismatch_cnt <= mismatch_cnt+1, saturating at all-ones (no wrap).
- mismatch stays set until reset.
- Reset asserted mid-operation clears the registers at once.
- Reset deassertion is synchronised by the system. The first capture occurs on the first rising edge with rst_n=1.
- Simultaneous input change and clock edge: the registers capture the values present before the edge (standard nonblocking semantics).
- In correct RTL, mismatch and mismatch_cnt remain 0 forever. They exist for fault/ECO detection.

Test Plan:
- Exhaustive WIDTH=1 sweep:
  - Stimulus: apply {sel,in1,in0}=000..111, holding each value 50 time units, then sample.
  - Required response: out_cond, out_if and out_case all equal the truth table above (0,1,0,1,0,0,1,1).
- Registered path:
  - Stimulus: rst_n=1, sel=1, in1=1, in0=0, one clk edge.
  - Required response: out_q=1. Then set sel=0 and apply one edge; out_q=0. Value trails its input by exactly one edge.
- Reset:
  - Stimulus: drive out_q=1, then pull rst_n=0 between clock edges.
  - Required response: out_q, mismatch and mismatch_cnt go to 0 immediately. Combinational outputs keep tracking inputs during reset.
- Checker quiet:
  - Stimulus: run 1000 random {sel,in1,in0} cycles.
  - Required response: mismatch=0, mismatch_cnt=0.
- Wide lanes:
  - Stimulus: WIDTH=8, in0=8'hA5, in1=8'h3C, toggle sel.
  - Required response: all three outputs show 8'hA5 for sel=0 and 8'h3C for sel=1.
- Counter saturation:
  - Stimulus: force out_if to ~out_cond for 300 edges, with CNT_W=8.
  - Required response: mismatch=1, mismatch_cnt=8'hFF (no wrap).

Source files
------------

// File: rtl/mux2to1_triple.sv
// rtl/mux2to1_triple.sv - 2:1 selector built three ways, with a registered copy and a path cross-checker
module mux2to1_triple #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] out_cond,
  output logic [WIDTH-1:0] out_if,
  output logic [WIDTH-1:0] out_case,
  output logic [WIDTH-1:0] out_q,
  output logic             mismatch,
  output logic [CNT_W-1:0] mismatch_cnt
);

  logic [WIDTH-1:0] cond_path;
  logic [WIDTH-1:0] if_path;
  logic [WIDTH-1:0] case_path;

  logic [WIDTH-1:0] out_q_q, out_q_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_known;
  logic             err;

  assign cond_path = sel ? in1 : in0;

  always_comb begin
    if (sel == 1'b1) begin
      if_path = in1;
    end else begin
      if_path = in0;
    end
  end

  always_comb begin
    case (sel)
      1'b1:    case_path = in1;
      default: case_path = in0;
    endcase
  end

  assign out_cond = cond_path;
  assign out_if   = if_path;
  assign out_case = case_path;

  // An unknown select evaluates to X here, which keeps the checker from firing on it
  assign sel_known = (sel == 1'b0) | (sel == 1'b1);
  assign err       = (cond_path != if_path) | (cond_path != case_path);

  always_comb begin
    out_q_d    = cond_path;
    mismatch_d = mismatch_q;
    cnt_d      = cnt_q;
    if (sel_known && err) begin
      mismatch_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_q    <= '0;
      mismatch_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_q_q    <= out_q_d;
      mismatch_q <= mismatch_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_q        = out_q_q;
  assign mismatch     = mismatch_q;
  assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_mux2to1_triple.sv
// tb/tb_mux2to1_triple.sv - directed self-checking bench for mux2to1_triple
module tb_mux2to1_triple;

  logic       clk;
  logic       rst_n;
  logic       in0, in1, sel;
  logic       out_cond, out_if, out_case, out_q, mismatch;
  logic [7:0] mismatch_cnt;

  logic [7:0] w_in0, w_in1;
  logic       w_sel;
  logic [7:0] w_cond, w_if, w_case, w_q;
  logic       w_mismatch;
  logic [7:0] w_cnt;

  int checks = 0;
  int errors = 0;

  mux2to1_triple #(.WIDTH(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .sel(sel),
    .out_cond(out_cond), .out_if(out_if), .out_case(out_case),
    .out_q(out_q), .mismatch(mismatch), .mismatch_cnt(mismatch_cnt)
  );

  mux2to1_triple #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in0(w_in0), .in1(w_in1), .sel(w_sel),
    .out_cond(w_cond), .out_if(w_if), .out_case(w_case),
    .out_q(w_q), .mismatch(w_mismatch), .mismatch_cnt(w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] tt;
    logic       m;
    tt    = 8'b1100_1010;
    rst_n = 1'b0;
    in0 = 1'b0; in1 = 1'b0; sel = 1'b0;
    w_in0 = 8'h00; w_in1 = 8'h00; w_sel = 1'b0;
    #12;
    chk("reset_out_q", 32'(out_q), 32'd0);
    chk("reset_mismatch", 32'(mismatch), 32'd0);
    chk("reset_cnt", 32'(mismatch_cnt), 32'd0);
    chk("reset_w_q", 32'(w_q), 32'd0);

    // exhaustive truth table, run while reset is held to show comb paths ignore it
    for (int v = 0; v < 8; v++) begin
      {sel, in1, in0} = 3'(v);
      #50;
      chk($sformatf("sweep_cond_%0d", v), 32'(out_cond), 32'(tt[v]));
      chk($sformatf("sweep_if_%0d", v), 32'(out_if), 32'(tt[v]));
      chk($sformatf("sweep_case_%0d", v), 32'(out_case), 32'(tt[v]));
    end
    chk("sweep_out_q_held", 32'(out_q), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    sel = 1'b1; in1 = 1'b1; in0 = 1'b0;
    @(posedge clk); #1;
    chk("reg_sel1", 32'(out_q), 32'd1);
    sel = 1'b0;
    #1;
    chk("reg_trails", 32'(out_q), 32'd1);
    @(posedge clk); #1;
    chk("reg_sel0", 32'(out_q), 32'd0);

    sel = 1'b1;
    @(posedge clk); #1;
    chk("pre_reset_q", 32'(out_q), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_q", 32'(out_q), 32'd0);
    chk("async_reset_mm", 32'(mismatch), 32'd0);
    chk("async_reset_cnt", 32'(mismatch_cnt), 32'd0);
    sel = 1'b0; in0 = 1'b1;
    #1;
    chk("reset_comb_cond", 32'(out_cond), 32'd1);
    chk("reset_comb_if", 32'(out_if), 32'd1);
    chk("reset_comb_case", 32'(out_case), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      {sel, in1, in0} = 3'($urandom_range(0, 7));
      m = sel ? in1 : in0;
      #1;
      chk("rand_cond", 32'(out_cond), 32'(m));
      @(posedge clk); #1;
      chk("rand_q", 32'(out_q), 32'(m));
    end
    chk("quiet_mismatch", 32'(mismatch), 32'd0);
    chk("quiet_cnt", 32'(mismatch_cnt), 32'd0);

    w_in0 = 8'hA5; w_in1 = 8'h3C; w_sel = 1'b0;
    #1;
    chk("wide_cond_0", 32'(w_cond), 32'hA5);
    chk("wide_if_0", 32'(w_if), 32'hA5);
    chk("wide_case_0", 32'(w_case), 32'hA5);
    w_sel = 1'b1;
    #1;
    chk("wide_cond_1", 32'(w_cond), 32'h3C);
    chk("wide_if_1", 32'(w_if), 32'h3C);
    chk("wide_case_1", 32'(w_case), 32'h3C);
    @(posedge clk); #1;
    chk("wide_q", 32'(w_q), 32'h3C);
    chk("wide_quiet", 32'(w_cnt), 32'd0);

    @(negedge clk);
    sel = 1'b0; in0 = 1'b0; in1 = 1'b0;
    force dut.if_path = 1'b1;
    @(posedge clk); #1;
    chk("inject_mm", 32'(mismatch), 32'd1);
    chk("inject_cnt1", 32'(mismatch_cnt), 32'd1);
    repeat (299) @(posedge clk);
    #1;
    chk("sat_mm", 32'(mismatch), 32'd1);
    chk("sat_cnt", 32'(mismatch_cnt), 32'hFF);
    release dut.if_path;
    @(posedge clk); #1;
    chk("sticky_mm", 32'(mismatch), 32'd1);
    chk("sticky_cnt", 32'(mismatch_cnt), 32'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("final_reset_mm", 32'(mismatch), 32'd0);
    chk("final_reset_cnt", 32'(mismatch_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
